// File: rtl/ddr_access_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ddr_access_pkg : command codes, FSM encoding and sizing helper for ddr_access
// Rev 1.0
// ============================================================================
package ddr_access_pkg;

    localparam logic [3:0] CMD_READ  = 4'b0001;
    localparam logic [3:0] CMD_WRITE = 4'b0010;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_ACK   = 3'd2,
        ST_CMD   = 3'd3,
        ST_DATA  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    function automatic int burst_cnt_width(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_access_burst_split.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ddr_access_burst_split : splits a beat count into commands of <= MAX_BURST
// Rev 1.0
// ============================================================================
module ddr_access_burst_split
    import ddr_access_pkg::*;
#(
    parameter int ADDR_W    = 27,
    parameter int LEN_W     = 12,
    parameter int MAX_BURST = 32,
    parameter int ADDR_STEP = 8
) (
    input  logic                                  i_ddr3_sclk,
    input  logic                                  i_rst_n,
    input  logic                                  i_load,
    input  logic [ADDR_W-1:0]                     i_addr,
    input  logic [LEN_W-1:0]                      i_len,
    input  logic                                  i_accept,
    output logic [ADDR_W-1:0]                     o_addr,
    output logic [burst_cnt_width(MAX_BURST)-1:0] o_burst_cnt,
    output logic                                  o_last
);

    localparam int              BCW     = burst_cnt_width(MAX_BURST);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [LEN_W-1:0]  w_burst;

    assign w_burst     = (rem_q > MAX_LEN) ? MAX_LEN : rem_q;
    assign o_burst_cnt = w_burst[BCW-1:0];
    assign o_addr      = addr_q;
    assign o_last      = (rem_q <= MAX_LEN);

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (i_load) begin
            addr_d = i_addr;
            rem_d  = i_len;
        end else if (i_accept) begin
            addr_d = addr_q + ADDR_W'(w_burst) * ADDR_W'(ADDR_STEP);
            rem_d  = rem_q - w_burst;
        end
    end

    always_ff @(posedge i_ddr3_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr_access_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ddr_access_ctrl : DDR3 request sequencer feeding the write/read buffer stage
// Rev 1.0
// ============================================================================
module ddr_access_ctrl
    import ddr_access_pkg::*;
#(
    parameter int ADDR_W    = 27,
    parameter int LEN_W     = 12,
    parameter int MAX_BURST = 32,
    parameter int ADDR_STEP = 8,
    parameter int RAM_AW    = 9
) (
    input  logic                                  i_ddr3_sclk,
    input  logic                                  i_rst_n,
    input  logic                                  i_init_done,
    input  logic                                  i_req,
    input  logic                                  i_req_wr_rdn,
    input  logic [ADDR_W-1:0]                     i_req_addr,
    input  logic [LEN_W-1:0]                      i_req_len,
    output logic                                  o_req_ack,
    output logic                                  o_ddr3_ack,
    output logic                                  o_ddr3_wr_rdn,
    output logic                                  o_ddr3_op_done,
    output logic [3:0]                            o_cmd,
    output logic                                  o_cmd_valid,
    input  logic                                  i_cmd_rdy,
    output logic [ADDR_W-1:0]                     o_cmd_addr,
    output logic [burst_cnt_width(MAX_BURST)-1:0] o_cmd_burst_cnt,
    input  logic                                  i_ddr3_wr_data_rdy,
    input  logic                                  i_ddr3_rd_data_vld,
    input  logic                                  i_ram_rd_en,
    input  logic                                  i_ram_wr_data_vld,
    output logic [RAM_AW-1:0]                     o_ram_rd_addr,
    output logic [RAM_AW-1:0]                     o_ram_wr_addr,
    output logic                                  o_busy,
    output logic                                  o_err_overrun
);

    state_e             state_q;
    logic               wr_rdn_q, ack_q, done_q, cmd_valid_q, busy_q, err_q;
    logic [3:0]         cmd_q;
    logic [LEN_W-1:0]   len_q, cnt_q, cnt_d;
    logic [RAM_AW-1:0]  ram_rd_addr_q, ram_wr_addr_q;

    logic w_sel_beat, w_counting, w_full, w_data_done;
    logic w_accept, w_load, w_split_last, w_overrun;

    assign w_sel_beat  = wr_rdn_q ? i_ddr3_wr_data_rdy : i_ddr3_rd_data_vld;
    assign w_counting  = (state_q == ST_CMD) || (state_q == ST_DATA);
    assign w_full      = (cnt_q == len_q);
    assign cnt_d       = (w_counting && w_sel_beat && !w_full) ? cnt_q + LEN_W'(1) : cnt_q;
    assign w_data_done = (cnt_d == len_q);
    assign w_accept    = cmd_valid_q && i_cmd_rdy;
    assign w_load      = (state_q == ST_IDLE) && i_req && i_init_done;

    // Any controller beat while idle, or a selected beat once the count is full.
    assign w_overrun = ((state_q == ST_IDLE) && (i_ddr3_wr_data_rdy || i_ddr3_rd_data_vld)) ||
                       ((w_counting || (state_q == ST_DONE)) && w_sel_beat && w_full);

    ddr_access_burst_split #(
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .MAX_BURST (MAX_BURST),
        .ADDR_STEP (ADDR_STEP)
    ) u_burst_split (
        .i_ddr3_sclk (i_ddr3_sclk),
        .i_rst_n     (i_rst_n),
        .i_load      (w_load),
        .i_addr      (i_req_addr),
        .i_len       (i_req_len),
        .i_accept    (w_accept),
        .o_addr      (o_cmd_addr),
        .o_burst_cnt (o_cmd_burst_cnt),
        .o_last      (w_split_last)
    );

    always_ff @(posedge i_ddr3_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            wr_rdn_q      <= 1'b0;
            ack_q         <= 1'b0;
            done_q        <= 1'b0;
            cmd_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            cmd_q         <= 4'd0;
            len_q         <= '0;
            cnt_q         <= '0;
            ram_rd_addr_q <= '0;
            ram_wr_addr_q <= '0;
        end else begin
            ack_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= cnt_d;
            if (w_overrun) begin
                err_q <= 1'b1;
            end

            if (state_q == ST_LATCH) begin
                ram_rd_addr_q <= '0;
                ram_wr_addr_q <= '0;
            end else begin
                if (i_ram_rd_en) begin
                    ram_rd_addr_q <= ram_rd_addr_q + RAM_AW'(1);
                end
                if (i_ram_wr_data_vld) begin
                    ram_wr_addr_q <= ram_wr_addr_q + RAM_AW'(1);
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_load) begin
                        state_q  <= ST_LATCH;
                        wr_rdn_q <= i_req_wr_rdn;
                        len_q    <= i_req_len;
                        busy_q   <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    state_q <= ST_ACK;
                    ack_q   <= 1'b1;
                    cnt_q   <= '0;
                end
                ST_ACK: begin
                    if (len_q == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q     <= ST_CMD;
                        cmd_valid_q <= 1'b1;
                        cmd_q       <= wr_rdn_q ? CMD_WRITE : CMD_READ;
                    end
                end
                ST_CMD: begin
                    // Completion waits for the last command even if data finished first.
                    if (w_accept && w_split_last) begin
                        cmd_valid_q <= 1'b0;
                        cmd_q       <= 4'd0;
                        if (w_data_done) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_data_done) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ack      = ack_q;
    assign o_ddr3_ack     = ack_q;
    assign o_ddr3_wr_rdn  = wr_rdn_q;
    assign o_ddr3_op_done = done_q;
    assign o_cmd          = cmd_q;
    assign o_cmd_valid    = cmd_valid_q;
    assign o_ram_rd_addr  = ram_rd_addr_q;
    assign o_ram_wr_addr  = ram_wr_addr_q;
    assign o_busy         = busy_q;
    assign o_err_overrun  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_access_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_ddr_access_ctrl : scoreboard bench for ddr_access_ctrl
// Rev 1.0
// ============================================================================
module tb_ddr_access_ctrl;

    localparam int ADDR_W    = 27;
    localparam int LEN_W     = 12;
    localparam int MAX_BURST = 32;
    localparam int ADDR_STEP = 8;
    localparam int RAM_AW    = 9;
    localparam int BCW       = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              init_done = 1'b1;
    logic              req = 1'b0;
    logic              req_wr = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [LEN_W-1:0]  req_len = '0;
    logic              cmd_rdy = 1'b1;
    logic              wr_data_rdy = 1'b0;
    logic              rd_data_vld = 1'b0;
    logic              ram_rd_en = 1'b0;
    logic              ram_wr_data_vld = 1'b0;

    logic              req_ack, ddr3_ack, ddr3_wr_rdn, op_done, cmd_valid, busy, err;
    logic [3:0]        cmd;
    logic [ADDR_W-1:0] cmd_addr;
    logic [BCW-1:0]    burst_cnt;
    logic [RAM_AW-1:0] ram_rd_addr, ram_wr_addr;

    typedef struct packed {
        logic [3:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic [BCW-1:0]    bc;
    } cmd_t;

    cmd_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_acc_cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   valid_cnt = 0;

    ddr_access_ctrl #(
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .MAX_BURST (MAX_BURST),
        .ADDR_STEP (ADDR_STEP),
        .RAM_AW    (RAM_AW)
    ) dut (
        .i_ddr3_sclk        (clk),
        .i_rst_n            (rst_n),
        .i_init_done        (init_done),
        .i_req              (req),
        .i_req_wr_rdn       (req_wr),
        .i_req_addr         (req_addr),
        .i_req_len          (req_len),
        .o_req_ack          (req_ack),
        .o_ddr3_ack         (ddr3_ack),
        .o_ddr3_wr_rdn      (ddr3_wr_rdn),
        .o_ddr3_op_done     (op_done),
        .o_cmd              (cmd),
        .o_cmd_valid        (cmd_valid),
        .i_cmd_rdy          (cmd_rdy),
        .o_cmd_addr         (cmd_addr),
        .o_cmd_burst_cnt    (burst_cnt),
        .i_ddr3_wr_data_rdy (wr_data_rdy),
        .i_ddr3_rd_data_vld (rd_data_vld),
        .i_ram_rd_en        (ram_rd_en),
        .i_ram_wr_data_vld  (ram_wr_data_vld),
        .o_ram_rd_addr      (ram_rd_addr),
        .o_ram_wr_addr      (ram_wr_addr),
        .o_busy             (busy),
        .o_err_overrun      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Command scoreboard: every valid cycle must present the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    chk("cmd_unexpected", cmd_valid, 1'b0);
                end else begin
                    chk("cmd_code", cmd, exp_q[0].cmd);
                    chk("cmd_addr", cmd_addr, exp_q[0].addr);
                    chk("cmd_burst", burst_cnt, exp_q[0].bc);
                    if (cmd_rdy) begin
                        void'(exp_q.pop_front());
                        last_acc_cyc = cyc;
                    end
                end
            end
            if (op_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic push_cmds(input logic wr, input int addr, input int len);
        int   rem;
        int   a;
        int   b;
        cmd_t e;
        rem = len;
        a   = addr;
        while (rem > 0) begin
            b      = (rem > MAX_BURST) ? MAX_BURST : rem;
            e.cmd  = wr ? 4'b0010 : 4'b0001;
            e.addr = ADDR_W'(a);
            e.bc   = BCW'(b);
            exp_q.push_back(e);
            a   = a + b * ADDR_STEP;
            rem = rem - b;
        end
    endtask

    task automatic issue(input logic wr, input int addr, input int len, output int ack_cyc);
        logic prev_wr;
        int   got;
        push_cmds(wr, addr, len);
        last_acc_cyc = 0;
        @(posedge clk);
        #1;
        req      = 1'b1;
        req_wr   = wr;
        req_addr = ADDR_W'(addr);
        req_len  = LEN_W'(len);
        prev_wr  = ddr3_wr_rdn;
        got      = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            if (req_ack) got = 1;
            else prev_wr = ddr3_wr_rdn;
        end
        req = 1'b0;
        chk("ack_seen", got, 1);
        chk("ack_pair", ddr3_ack, req_ack);
        chk("wr_rdn_pre_ack", prev_wr, wr);
        ack_cyc = cyc;
    endtask

    task automatic run_req(input logic wr, input int addr, input int len,
                           input int stall, input int extra);
        int ack_cyc;
        int last_beat;
        int exp_done;
        int d0;
        int v0;
        d0 = done_cnt;
        v0 = valid_cnt;
        issue(wr, addr, len, ack_cyc);
        last_beat = ack_cyc;
        fork
            begin
                if (stall > 0) begin
                    cmd_rdy = 1'b0;
                    repeat (stall) @(posedge clk);
                    #1 cmd_rdy = 1'b1;
                end
            end
            begin
                for (int i = 0; i < len + extra; i++) begin
                    @(posedge clk);
                    #1;
                    if (wr) begin wr_data_rdy = 1'b1; ram_rd_en = 1'b1; end
                    else begin rd_data_vld = 1'b1; ram_wr_data_vld = 1'b1; end
                    if (i < len) last_beat = cyc;
                end
                @(posedge clk);
                #1;
                wr_data_rdy = 1'b0; rd_data_vld = 1'b0;
                ram_rd_en = 1'b0; ram_wr_data_vld = 1'b0;
            end
        join
        for (int i = 0; i < 300 && done_cnt == d0; i++) @(negedge clk);
        exp_done = ack_cyc;
        if (last_beat > exp_done) exp_done = last_beat;
        if (last_acc_cyc > exp_done) exp_done = last_acc_cyc;
        exp_done = exp_done + 1;
        chk("done_cycle", done_cyc, exp_done);
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt - d0, 1);
        chk("idle_after", busy, 1'b0);
        chk("cmds_left", exp_q.size(), 0);
        if (len == 0) chk("len0_no_cmd", valid_cnt - v0, 0);
        if (wr) chk("ram_rd_addr", ram_rd_addr, (len + extra) % (1 << RAM_AW));
        else    chk("ram_wr_addr", ram_wr_addr, (len + extra) % (1 << RAM_AW));
    endtask

    initial begin
        int ackc;
        do_reset();
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", req_ack, 1'b0);
        chk("rst_wr_rdn", ddr3_wr_rdn, 1'b0);
        chk("rst_valid", cmd_valid, 1'b0);
        chk("rst_ram_rd", ram_rd_addr, 0);
        chk("rst_err", err, 1'b0);

        // Request without calibration must be held off.
        init_done = 1'b0;
        req = 1'b1; req_wr = 1'b1; req_len = 12'd4;
        repeat (5) @(negedge clk);
        chk("no_init_busy", busy, 1'b0);
        req = 1'b0;
        init_done = 1'b1;

        run_req(1'b1, 'h100, 8, 0, 0);
        run_req(1'b0, 0, 70, 0, 0);
        run_req(1'b1, 'h2000, 40, 5, 0);
        run_req(1'b1, 'h300, 4, 4, 0);
        run_req(1'b0, 'h10, 0, 0, 0);
        chk("no_err_yet", err, 1'b0);

        // Async reset in the middle of a transfer.
        issue(1'b1, 'h40, 8, ackc);
        repeat (3) begin
            @(posedge clk);
            #1 wr_data_rdy = 1'b1;
        end
        @(posedge clk);
        #1 wr_data_rdy = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_wr_rdn", ddr3_wr_rdn, 1'b0);
        chk("arst_valid", cmd_valid, 1'b0);
        chk("arst_cmd_addr", cmd_addr, 0);
        chk("arst_burst", burst_cnt, 0);
        chk("arst_done", op_done, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_req(1'b0, 'h80, 8, 0, 0);

        // Beat while idle sets the sticky overrun flag.
        @(posedge clk);
        #1 rd_data_vld = 1'b1;
        @(posedge clk);
        #1 rd_data_vld = 1'b0;
        @(negedge clk);
        chk("idle_beat_err", err, 1'b1);
        repeat (4) @(negedge clk);
        chk("err_sticky", err, 1'b1);
        do_reset();
        @(negedge clk);
        chk("err_cleared", err, 1'b0);

        run_req(1'b1, 'h500, 8, 0, 1);
        chk("extra_beat_err", err, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
